// File: rtl/gpio_f2m_debounce.sv
// Fabric-side GPIO input front end: per-channel 2-flop sync, debounce,
// edge pulses, sticky event flags and a combined interrupt toward the MSS.

module gpio_f2m_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter logic        RESET_BIT       = 1'b0,
  parameter logic        RISE_ON         = 1'b1,
  parameter logic        FALL_ON         = 1'b0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic pin,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pending
);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 sync1, sync2;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 differ, accept, set;

  assign differ = (sync2 != level);
  assign accept = differ && (cnt == CNT_LAST);
  assign set    = accept && ((sync2 && RISE_ON) || (!sync2 && FALL_ON));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync1 <= RESET_BIT;
      sync2 <= RESET_BIT;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Any return to the current level drops the count: a bounce restarts the window.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt   <= '0;
      level <= RESET_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept && sync2;
      fall <= accept && !sync2;
      if (!differ || accept) cnt <= '0;
      else                   cnt <= cnt + CNT_ONE;
      if (accept) level <= sync2;
    end
  end

  // A new event beats a concurrent firmware clear.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  pending <= 1'b0;
    else if (set) pending <= 1'b1;
    else if (clr) pending <= 1'b0;
  end
endmodule

module gpio_f2m_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter logic [7:0]  RESET_LEVEL     = 8'h00,
  parameter logic [7:0]  RISE_EN         = 8'hFF,
  parameter logic [7:0]  FALL_EN         = 8'h00
) (
  input  logic       FAB_CCC_GL0,
  input  logic       FAB_RESET_N,
  input  logic [7:0] PIN_IN,
  input  logic [7:0] EVT_CLR,
  output logic [7:0] GPIO_F2M,
  output logic [7:0] EDGE_RISE,
  output logic [7:0] EDGE_FALL,
  output logic [7:0] EVT_PENDING,
  output logic       IRQ_F2M
);
  localparam int unsigned NUM_LANES = 8;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    gpio_f2m_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH),
      .RESET_BIT      (RESET_LEVEL[i]),
      .RISE_ON        (RISE_EN[i]),
      .FALL_ON        (FALL_EN[i])
    ) u_lane (
      .gclk   (FAB_CCC_GL0),
      .grst_n (FAB_RESET_N),
      .pin    (PIN_IN[i]),
      .clr    (EVT_CLR[i]),
      .level  (GPIO_F2M[i]),
      .rise   (EDGE_RISE[i]),
      .fall   (EDGE_FALL[i]),
      .pending(EVT_PENDING[i])
    );
  end

  always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) IRQ_F2M <= 1'b0;
    else              IRQ_F2M <= |EVT_PENDING;
  end
endmodule

// File: tb/tb_gpio_f2m_debounce.sv
// Directed bench for gpio_f2m_debounce: stimulus queues expected edge events,
// a monitor pops and checks them whenever an edge pulse appears.
module tb_gpio_f2m_debounce;
  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] pin = 8'h00;
  logic [7:0] clr = 8'h00;
  logic [7:0] gpio, rise, fall, pend;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    string      name;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] gpio;
    int         cyc;
  } exp_t;
  exp_t q[$];

  gpio_f2m_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (16),
    .RESET_LEVEL    (8'h00),
    .RISE_EN        (8'hFF),
    .FALL_EN        (8'h01)
  ) dut (
    .FAB_CCC_GL0(clk),
    .FAB_RESET_N(rst_n),
    .PIN_IN     (pin),
    .EVT_CLR    (clr),
    .GPIO_F2M   (gpio),
    .EDGE_RISE  (rise),
    .EDGE_FALL  (fall),
    .EVT_PENDING(pend),
    .IRQ_F2M    (irq)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pin change driven now is captured on the next edge; pulse seen 6 negedges later.
  task automatic push(input string name, input logic [7:0] r, input logic [7:0] f,
                      input logic [7:0] g);
    exp_t e;
    e.name = name; e.rise = r; e.fall = f; e.gpio = g; e.cyc = cyc + 6;
    q.push_back(e);
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && ((rise | fall) != 8'h00)) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_edge actual rise=%h fall=%h required none (cyc %0d)",
                 rise, fall, cyc);
      end else begin
        e = q.pop_front();
        chk8({e.name, "_rise"}, rise, e.rise);
        chk8({e.name, "_fall"}, fall, e.fall);
        chk8({e.name, "_gpio"}, gpio, e.gpio);
        chki({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with no clock
    pin = 8'hFF;
    #1 rst_n = 1'b0;
    #2;
    chk8("rst_gpio", gpio, 8'h00);
    chk8("rst_rise", rise, 8'h00);
    chk8("rst_fall", fall, 8'h00);
    chk8("rst_pend", pend, 8'h00);
    chk8("rst_irq", {7'd0, irq}, 8'h00);
    clk_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    push("rst_rel", 8'hFF, 8'h00, 8'hFF);
    tick(5);
    chk8("rel_gpio_early", gpio, 8'h00);
    tick(1);
    chk8("rel_pend", pend, 8'hFF);
    chk8("rel_irq_lag", {7'd0, irq}, 8'h00);
    tick(1);
    chk8("rel_irq", {7'd0, irq}, 8'h01);
    chk8("rel_rise_one", rise, 8'h00);
    chki("rel_drain", q.size(), 0);

    // clear all flags
    clr = 8'hFF;
    tick(1);
    chk8("clr_pend", pend, 8'h00);
    clr = 8'h00;
    tick(1);
    chk8("clr_irq", {7'd0, irq}, 8'h00);

    // ch2..7 fall, no fall enable there
    pin = 8'h03;
    push("fall_hi", 8'h00, 8'hFC, 8'h03);
    tick(8);
    chk8("fall_hi_pend", pend, 8'h00);
    chki("fall_hi_drain", q.size(), 0);

    // glitch on ch3, 3 cycles
    pin = 8'h0B;
    tick(3);
    pin = 8'h03;
    tick(10);
    chk8("glitch_gpio", gpio, 8'h03);
    chk8("glitch_pend", pend, 8'h00);

    // bounce on ch2
    pin = 8'h07;
    tick(3);
    pin = 8'h03;
    tick(1);
    pin = 8'h07;
    push("bounce", 8'h04, 8'h00, 8'h07);
    tick(5);
    chk8("bounce_gpio_early", gpio, 8'h03);
    tick(1);
    chk8("bounce_gpio", gpio, 8'h07);
    tick(3);
    chk8("bounce_pend", pend, 8'h04);
    chki("bounce_drain", q.size(), 0);
    clr = 8'h04;
    tick(1);
    chk8("bounce_clr", pend, 8'h00);
    clr = 8'h00;
    tick(2);

    // ch0 and ch1 fall, only ch0 flags
    pin = 8'h04;
    push("fallmask", 8'h00, 8'h03, 8'h04);
    tick(6);
    chk8("fallmask_pend", pend, 8'h01);
    tick(1);
    chk8("fallmask_irq", {7'd0, irq}, 8'h01);
    chki("fallmask_drain", q.size(), 0);
    clr = 8'h01;
    tick(1);
    chk8("fallmask_clr", pend, 8'h00);
    clr = 8'h00;
    tick(1);
    chk8("fallmask_irq_off", {7'd0, irq}, 8'h00);

    // set/clear collision on ch4
    pin = 8'h14;
    push("collide", 8'h10, 8'h00, 8'h14);
    tick(5);
    clr = 8'h10;
    tick(1);
    chk8("collide_set_wins", pend, 8'h10);
    tick(1);
    chk8("collide_clr", pend, 8'h00);
    chk8("collide_irq_lag", {7'd0, irq}, 8'h01);
    clr = 8'h00;
    tick(1);
    chk8("collide_irq_off", {7'd0, irq}, 8'h00);
    chki("collide_drain", q.size(), 0);

    // reset after two counted cycles on ch5
    pin = 8'h34;
    tick(4);
    rst_n = 1'b0;
    #2;
    chk8("midrst_gpio", gpio, 8'h00);
    chk8("midrst_pend", pend, 8'h00);
    chk8("midrst_irq", {7'd0, irq}, 8'h00);
    tick(2);
    rst_n = 1'b1;
    push("midrst", 8'h34, 8'h00, 8'h34);
    tick(5);
    chk8("midrst_gpio_early", gpio, 8'h00);
    tick(1);
    chk8("midrst_gpio_late", gpio, 8'h34);
    tick(2);
    chk8("midrst_pend2", pend, 8'h34);
    chk8("midrst_irq2", {7'd0, irq}, 8'h01);
    chki("midrst_drain", q.size(), 0);

    tick(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
